// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream to instruction-memory loader; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module instr_mem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] IDLE = 3'd0, RECV = 3'd1, WRITE = 3'd2, DONE = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] FIN = CHECK;
`else
  localparam logic [2:0] FIN = DONE;
`endif
  localparam logic [ADDR_W:0] MAX = {1'b1, {ADDR_W{1'b0}}};
  logic [2:0] state, nxt;
  logic [1:0] idx;
  logic [ADDR_W:0] len, cnt, len_sat;
  logic xfer, go, rdy_nxt;
  assign xfer = byte_valid & byte_ready;
  assign go = (state == IDLE) & start;
  assign len_sat = len_words > MAX ? MAX : len_words;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign rdy_nxt = (nxt == RECV) || (nxt == CHECK);
`else
  assign rdy_nxt = nxt == RECV;
  assign error = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (len_sat == '0 ? FIN : RECV) : IDLE;
      RECV:  nxt = xfer && idx == 2'd3 ? WRITE : RECV;
      WRITE: nxt = cnt + 1'b1 == len ? FIN : RECV;
`ifdef LOADER_CHECKSUM_EN
      CHECK: nxt = xfer ? (byte_data == csum ? DONE : IDLE) : CHECK;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      cnt <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      byte_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state <= nxt;
      byte_ready <= rdy_nxt;
      mem_we <= nxt == WRITE;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      if (go) begin
        cpu_hold <= 1'b1;
        idx <= '0;
        mem_waddr <= '0;
        cnt <= '0;
        len <= len_sat;
      end
      if (nxt == DONE) cpu_hold <= 1'b0;
      if (state == RECV && xfer) begin
        mem_wdata[{idx, 3'b000} +: 8] <= byte_data;
        idx <= idx + 1'b1;
      end
      if (state == WRITE) begin
        mem_waddr <= mem_waddr + 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
      error <= 1'b0;
    end else begin
      if (go) begin
        csum <= '0;
        error <= 1'b0;
      end
      if (state == RECV && xfer) csum <= csum ^ byte_data;
      if (state == CHECK && xfer && byte_data != csum) error <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed bench for instr_mem_loader (default ADDR_W=10, optional LOADER_CHECKSUM_EN)
module tb_instr_mem_loader;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [10:0] len_words = '0;
  logic [7:0] byte_data = '0;
  logic byte_ready, mem_we, cpu_hold, busy, done, error;
  logic [9:0] mem_waddr;
  logic [31:0] mem_wdata;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  int n_assert = 0, n_fail = 0;
  int cyc = 0, nw = 0, ndone = 0, done_cyc = 0;
  logic hold_at_done = 1'b1;
  logic [9:0] wa [0:4095];
  logic [31:0] wd [0:4095];
  logic [7:0] bs [0:4199];
  int k = 0, st = 0, w0 = 0, d0 = 0;

  instr_mem_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_we) begin
      wa[nw] <= mem_waddr;
      wd[nw] <= mem_wdata;
      nw <= nw + 1;
    end
    if (done) begin
      ndone <= ndone + 1;
      done_cyc <= cyc;
      hold_at_done <= cpu_hold;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic prep(input int n, input bit bad);
    logic [7:0] x = '0;
    for (int i = 0; i < n; i++) x ^= bs[i];
    bs[n] = bad ? 8'h00 : x;
  endtask

  task automatic set8();
    bs[0] = 8'h13; bs[1] = 8'h00; bs[2] = 8'h00; bs[3] = 8'h00;
    bs[4] = 8'h93; bs[5] = 8'h00; bs[6] = 8'h10; bs[7] = 8'h00;
  endtask

  task automatic start_load(input logic [10:0] len);
    w0 = nw;
    d0 = ndone;
    len_words = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    st = cyc;
    k = 0;
  endtask

  task automatic feed(input int n, input bit tog, input bit wait_idle);
    int t = 0;
    bit ph = 1'b1;
    bit x;
    while ((k < n || (wait_idle && busy)) && t < 6000) begin
      byte_valid = (k < n) && (!tog || ph);
      byte_data = bs[k];
      @(negedge clk);
      x = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (x) k++;
      ph = !ph;
      t++;
    end
    byte_valid = 1'b0;
    chk("feed_in_bound", 32'(t < 6000), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_waddr", 32'(mem_waddr), 0);
    chk("rst_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);

    // two words, byte_valid held high
    set8();
    prep(8, 1'b0);
    start_load(11'd2);
    chk("a_busy", 32'(busy), 1);
    chk("a_ready", 32'(byte_ready), 1);
    feed(8 + CK, 1'b0, 1'b1);
    chk("a_nwrites", 32'(nw - w0), 2);
    chk("a_addr0", 32'(wa[w0]), 0);
    chk("a_data0", wd[w0], 32'h00000013);
    chk("a_addr1", 32'(wa[w0 + 1]), 1);
    chk("a_data1", wd[w0 + 1], 32'h00100093);
    chk("a_ndone", 32'(ndone - d0), 1);
    chk("a_done_lat", 32'(done_cyc - st), 32'(10 + CK));
    chk("a_hold_at_done", 32'(hold_at_done), 0);
    chk("a_hold_after", 32'(cpu_hold), 0);
    chk("a_busy_after", 32'(busy), 0);
    chk("a_error", 32'(error), 0);

    // same stream, byte_valid toggling
    start_load(11'd2);
    feed(8 + CK, 1'b1, 1'b1);
    chk("b_nwrites", 32'(nw - w0), 2);
    chk("b_data0", wd[w0], 32'h00000013);
    chk("b_addr1", 32'(wa[w0 + 1]), 1);
    chk("b_data1", wd[w0 + 1], 32'h00100093);
    chk("b_ndone", 32'(ndone - d0), 1);
    chk("b_done_later", 32'(done_cyc - st > 10 + CK), 1);

    // zero-length load
    prep(0, 1'b0);
    start_load(11'd0);
    feed(CK, 1'b0, 1'b1);
    chk("c_nwrites", 32'(nw - w0), 0);
    chk("c_ndone", 32'(ndone - d0), 1);
    chk("c_done_next_cycle", 32'(done_cyc - st), 32'(CK));

    // reset after byte 2 of word 1
    set8();
    prep(8, 1'b0);
    start_load(11'd2);
    feed(7, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("d_rst_we", 32'(mem_we), 0);
    chk("d_rst_busy", 32'(busy), 0);
    chk("d_rst_ready", 32'(byte_ready), 0);
    chk("d_rst_hold", 32'(cpu_hold), 1);
    chk("d_rst_waddr", 32'(mem_waddr), 0);
    chk("d_rst_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    byte_valid = 1'b1;
    byte_data = bs[7];
    repeat (5) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("d_nwrites", 32'(nw - w0), 1);
    chk("d_no_done", 32'(ndone - d0), 0);
    chk("d_hold_kept", 32'(cpu_hold), 1);
    bs[0] = 8'hAA; bs[1] = 8'hBB; bs[2] = 8'hCC; bs[3] = 8'hDD;
    prep(4, 1'b0);
    start_load(11'd1);
    feed(4 + CK, 1'b0, 1'b1);
    chk("d_new_addr", 32'(wa[w0]), 0);
    chk("d_new_data", wd[w0], 32'hDDCCBBAA);
    chk("d_new_hold", 32'(cpu_hold), 0);

    // start while busy is ignored
    set8();
    prep(8, 1'b0);
    start_load(11'd2);
    feed(3, 1'b0, 1'b0);
    len_words = 11'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("e_busy", 32'(busy), 1);
    feed(8 + CK, 1'b0, 1'b1);
    byte_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("e_nwrites", 32'(nw - w0), 2);
    chk("e_data1", wd[w0 + 1], 32'h00100093);
    chk("e_ndone", 32'(ndone - d0), 1);

    // oversize length saturates to 1024 words
    for (int i = 0; i < 4096; i++) bs[i] = 8'(i);
    prep(4096, 1'b0);
    start_load(11'h7FF);
    feed(4096 + CK, 1'b0, 1'b1);
    chk("f_nwrites", 32'(nw - w0), 1024);
    chk("f_last_addr", 32'(wa[w0 + 1023]), 1023);
    chk("f_last_data", wd[w0 + 1023], 32'hFFFEFDFC);
    chk("f_ndone", 32'(ndone - d0), 1);

`ifdef LOADER_CHECKSUM_EN
    set8();
    prep(8, 1'b1);
    start_load(11'd2);
    feed(9, 1'b0, 1'b1);
    chk("g_error", 32'(error), 1);
    chk("g_no_done", 32'(ndone - d0), 0);
    chk("g_hold", 32'(cpu_hold), 1);
    prep(0, 1'b0);
    start_load(11'd0);
    chk("g_error_cleared", 32'(error), 0);
    feed(1, 1'b0, 1'b1);
    chk("g_ndone", 32'(ndone - d0), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
